ativiade5_mem_test_master: RTL and testbench

- Avalon-MM initiator that drives the on-chip RAM's s1 slave port from the master side.
- Fills a word range with a deterministic pattern, reads it back and compares, or does both in sequence.
- Sits beside the RAM under the system interconnect; used for bring-up self-test and for pre-loading buffers without the CPU.

---
 rtl/ativiade5_mem_test_pkg.sv | 30 +++
 rtl/ativiade5_mem_test_master_pattern.sv | 49 ++++
 rtl/ativiade5_mem_test_master.sv | 201 ++++++++++++++++++++
 tb/tb_ativiade5_mem_test_master.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ativiade5_mem_test_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ativiade5_mem_test_pkg                                          |
// | Purpose  : Shared types and constants for the Avalon-MM RAM test master.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package ativiade5_mem_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_FIN     = 3'd4
    } state_t;

    localparam logic [1:0] MODE_FILL        = 2'b00;
    localparam logic [1:0] MODE_VERIFY      = 2'b01;
    localparam logic [1:0] MODE_FILL_VERIFY = 2'b10;

    localparam logic [31:0] LFSR_TAPS          = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_ZERO_SUB = 32'h0000_0001;

    // Right-shifting Galois step: feedback taps applied when bit 0 falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ativiade5_mem_test_master_pattern.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ativiade5_mem_test_pattern                                      |
// | Purpose  : Test-data generator; incrementing count, or a Galois LFSR when  |
// |            MEM_TEST_LFSR_EN is defined.                                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ativiade5_mem_test_pattern
    import ativiade5_mem_test_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] r_data;

`ifdef MEM_TEST_LFSR_EN
    // An all-zero LFSR state would lock up, so a zero seed is substituted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= (seed == '0) ? LFSR_SEED_ZERO_SUB : seed;
        end else if (advance) begin
            r_data <= lfsr_step(r_data);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= seed;
        end else if (advance) begin
            r_data <= r_data + DATA_W'(1);
        end
    end
`endif

    assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/ativiade5_mem_test_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ativiade5_mem_test_master                                       |
// | Purpose  : Avalon-MM initiator that fills and/or verifies a RAM word range.|
// |            Define MEM_TEST_LFSR_EN for an LFSR pattern instead of a count. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ativiade5_mem_test_master
    import ativiade5_mem_test_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic              avm_read,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [BE_W-1:0]   avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam logic [ADDR_W:0]   c_one_len  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] c_one_addr = ADDR_W'(1);

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_index;
    logic [DATA_W-1:0] r_seed;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              r_write;
    logic              r_read;
    logic [ADDR_W:0]   r_err_count;
    logic [ADDR_W-1:0] r_first_err;

    logic              w_last;
    logic              w_wr_acc;
    logic              w_rd_valid;
    logic              w_mismatch;
    logic              w_pat_load;
    logic              w_pat_adv;
    logic [DATA_W-1:0] w_pat_seed;
    logic [DATA_W-1:0] w_pat_data;

    assign w_last     = (r_index == (r_len - c_one_len));
    assign w_wr_acc   = r_write & ~avm_waitrequest;
    assign w_rd_valid = (r_state == ST_RD_WAIT) & avm_readdatavalid;
    assign w_mismatch = w_rd_valid & (avm_readdata != w_pat_data);

    // The generator tracks pattern(index): loaded at start, reloaded when a
    // fill hands over to verify, and stepped once per completed word.
    assign w_pat_load = ((r_state == ST_IDLE) & start)
                      | (w_wr_acc & w_last & (r_mode == MODE_FILL_VERIFY));
    assign w_pat_seed = (r_state == ST_IDLE) ? seed : r_seed;
    assign w_pat_adv  = w_wr_acc | w_rd_valid;

    ativiade5_mem_test_pattern #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .clk     (clk),
        .reset   (reset),
        .load    (w_pat_load),
        .advance (w_pat_adv),
        .seed    (w_pat_seed),
        .data    (w_pat_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_FILL;
            r_base      <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_index     <= '0;
            r_seed      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_err_count <= '0;
            r_first_err <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode      <= (mode == 2'b11) ? MODE_FILL : mode;
                        r_base      <= base_addr;
                        r_addr      <= base_addr;
                        r_len       <= length;
                        r_seed      <= seed;
                        r_index     <= '0;
                        r_error     <= 1'b0;
                        r_err_count <= '0;
                        r_first_err <= '0;
                        if (length == '0) begin
                            r_state <= ST_FIN;
                        end else if (mode == MODE_VERIFY) begin
                            r_state <= ST_RD_REQ;
                            r_read  <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_WR;
                            r_write <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (!avm_waitrequest) begin
                        r_addr  <= r_addr + c_one_addr;
                        r_index <= r_index + c_one_len;
                        if (w_last) begin
                            r_write <= 1'b0;
                            if (r_mode == MODE_FILL_VERIFY) begin
                                r_index <= '0;
                                r_addr  <= r_base;
                                r_read  <= 1'b1;
                                r_state <= ST_RD_REQ;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= ST_FIN;
                            end
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (!avm_waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        if (w_mismatch) begin
                            r_error <= 1'b1;
                            if (r_err_count != '1) begin
                                r_err_count <= r_err_count + c_one_len;
                            end
                            if (!r_error) begin
                                r_first_err <= r_addr;
                            end
                        end
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_FIN;
                        end else begin
                            r_index <= r_index + c_one_len;
                            r_addr  <= r_addr + c_one_addr;
                            r_read  <= 1'b1;
                            r_state <= ST_RD_REQ;
                        end
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err;
    assign avm_address    = r_addr;
    assign avm_write      = r_write;
    assign avm_read       = r_read;
    assign avm_chipselect = r_write | r_read;
    assign avm_writedata  = w_pat_data;
    assign avm_byteenable = {BE_W{1'b1}};

endmodule
`default_nettype wire

// File: tb/tb_ativiade5_mem_test_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ativiade5_mem_test_master                                    |
// | Purpose  : Self-checking bench with a RAM/bus model and pattern reference. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ativiade5_mem_test_master;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [1:0]    mode;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [DW-1:0] seed;
    logic          busy, done, error;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic [AW-1:0] avm_address;
    logic          avm_chipselect, avm_write, avm_read;
    logic [DW-1:0] avm_writedata;
    logic [3:0]    avm_byteenable;
    logic          avm_waitrequest, avm_readdatavalid;
    logic [DW-1:0] avm_readdata;

    ativiade5_mem_test_master #(.ADDR_W(AW), .DATA_W(DW), .BE_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
        .length(length), .seed(seed), .busy(busy), .done(done), .error(error),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write(avm_write), .avm_read(avm_read), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [31:0] ram [0:1023];
    int          exp_wr_addr[$];
    logic [31:0] exp_wr_data[$];
    int          exp_rd_addr[$];
    int          log_wr_addr[$];
    logic [31:0] log_wr_data[$];
    int          log_wr_cyc[$];
    int          log_rd_addr[$];
    int          exp_err_cnt, exp_first;
    bit          stall_en = 0, junk_en = 0;
    int          rd_lat_max = 1;
    int          force_stall_idx = -1, force_stall_cnt = 0;
    int          wr_accepted, done_count, done_cyc, start_cyc, rw_seen, stall_seen;
    bit          pend = 0, prev_stall = 0;
    int          pend_cnt;
    logic [AW-1:0] pend_addr, prev_addr;
    logic [31:0]   prev_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference pattern for word i of a run started with seed s.
    function automatic logic [31:0] pat(input logic [31:0] s, input int i);
`ifdef MEM_TEST_LFSR_EN
        logic [31:0] v;
        v = (s == 32'h0) ? 32'h1 : s;
        for (int k = 0; k < i; k++) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
        return v;
`else
        return s + 32'(i);
`endif
    endfunction

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Bus/RAM model and per-cycle protocol checker.
    initial begin : bus
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            avm_readdata = $urandom;
            if (reset) begin
                pend = 0; prev_stall = 0; avm_waitrequest = 1'b0;
            end else begin
                chk("chipselect", avm_chipselect, avm_read | avm_write);
                chk("byteenable", avm_byteenable, 4'hf);
                chk("rw_exclusive", avm_read & avm_write, 1'b0);
                if (avm_read | avm_write) begin chk("busy_during_req", busy, 1'b1); rw_seen++; end
                if (prev_stall) begin
                    chk("stall_write_held", avm_write, 1'b1);
                    chk("stall_addr", avm_address, prev_addr);
                    chk("stall_data", avm_writedata, prev_data);
                end
                if (pend) chk("single_outstanding", avm_read, 1'b0);
                if (done) begin done_count++; done_cyc = cyc; chk("done_not_busy", busy, 1'b0); end
                if (pend) begin
                    if (pend_cnt == 0) begin
                        avm_readdatavalid = 1'b1; avm_readdata = ram[pend_addr]; pend = 0;
                    end else pend_cnt--;
                end else if (junk_en && $urandom_range(9) == 0) avm_readdatavalid = 1'b1;
                if (force_stall_cnt > 0 && avm_write && wr_accepted == force_stall_idx) begin
                    avm_waitrequest = 1'b1; force_stall_cnt--; stall_seen++;
                end else avm_waitrequest = stall_en && ($urandom_range(3) == 0);
                if (avm_write && !avm_waitrequest) begin
                    if (exp_wr_addr.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
                    else begin
                        chk("wr_addr", avm_address, exp_wr_addr.pop_front());
                        chk("wr_data", avm_writedata, exp_wr_data.pop_front());
                    end
                    ram[avm_address] = avm_writedata;
                    log_wr_addr.push_back(int'(avm_address));
                    log_wr_data.push_back(avm_writedata);
                    log_wr_cyc.push_back(cyc);
                    wr_accepted++;
                end
                if (avm_read && !avm_waitrequest) begin
                    if (exp_rd_addr.size() == 0) chk("unexpected_read", 1'b1, 1'b0);
                    else chk("rd_addr", avm_address, exp_rd_addr.pop_front());
                    log_rd_addr.push_back(int'(avm_address));
                    pend = 1; pend_cnt = $urandom_range(rd_lat_max - 1, 0); pend_addr = avm_address;
                end
                prev_stall = avm_write && avm_waitrequest;
                prev_addr = avm_address;
                prev_data = avm_writedata;
            end
        end
    end

    task automatic preload(input int b, input int len, input logic [31:0] sd);
        for (int i = 0; i < len; i++) ram[(b + i) % 1024] = pat(sd, i);
    endtask

    task automatic issue_cmd(input logic [1:0] md, input int b, input int len, input logic [31:0] sd);
        int m, a;
        logic [31:0] w;
        m = (md == 2'd3) ? 0 : int'(md);
        exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd_addr.delete();
        log_wr_addr.delete(); log_wr_data.delete(); log_wr_cyc.delete(); log_rd_addr.delete();
        wr_accepted = 0; done_count = 0; rw_seen = 0; stall_seen = 0;
        exp_err_cnt = 0; exp_first = 0;
        for (int i = 0; i < len; i++) begin
            a = (b + i) % 1024;
            if (m != 1) begin exp_wr_addr.push_back(a); exp_wr_data.push_back(pat(sd, i)); end
            if (m != 0) begin
                exp_rd_addr.push_back(a);
                w = (m != 1) ? pat(sd, i) : ram[a];
                if (w != pat(sd, i)) begin
                    if (exp_err_cnt == 0) exp_first = a;
                    exp_err_cnt++;
                end
            end
        end
        start = 1'b1; mode = md; base_addr = b[AW-1:0]; length = len[AW:0]; seed = sd;
        start_cyc = cyc;
        step();
        start = 1'b0; mode = 2'($urandom); base_addr = AW'($urandom);
        length = (AW+1)'($urandom); seed = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_count == 0 && n < 20000) begin step(); n++; end
        chk("done_seen", done_count != 0, 1'b1);
        step(); step();
        chk("done_once", done_count, 1);
        chk("busy_idle", busy, 1'b0);
        chk("wr_queue_empty", exp_wr_addr.size(), 0);
        chk("rd_queue_empty", exp_rd_addr.size(), 0);
        chk("error", error, exp_err_cnt != 0);
        chk("err_count", err_count, exp_err_cnt);
        chk("first_err_addr", first_err_addr, exp_first);
    endtask

    task automatic poke_start();
        step(); step();
        chk("poke_busy", busy, 1'b1);
        start = 1'b1; mode = 2'd1; base_addr = AW'($urandom); length = 11'd3;
        step();
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_first_err"}, first_err_addr, 0);
        chk({tag, "_rw_cs"}, {avm_read, avm_write, avm_chipselect}, 3'b000);
        chk({tag, "_addr"}, avm_address, 0);
        chk({tag, "_wdata"}, avm_writedata, 0);
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [1:0]  md;
        int          b, len, n;
        logic [31:0] sd;
        for (int i = 0; i < 1024; i++) ram[i] = $urandom;
        reset = 1'b1; start = 1'b0; mode = '0; base_addr = '0; length = '0; seed = '0;
        repeat (3) step();
        chk_all_zero("reset");
        reset = 1'b0;
        step();

        // Fill-then-verify, no stalls, 1-cycle read latency.
        issue_cmd(2'd2, 0, 4, 32'h100);
        wait_done();
        chk("t1_reads", log_rd_addr.size(), 4);
        chk("t1_back_to_back", log_wr_cyc[3] - log_wr_cyc[0], 3);
        chk("t1_last_addr", log_wr_addr[3], 3);
`ifndef MEM_TEST_LFSR_EN
        chk("t1_data0", log_wr_data[0], 32'h100);
        chk("t1_data3", log_wr_data[3], 32'h103);
`endif

        // Fill with wrap and a 3-cycle stall on the second word.
        force_stall_idx = 1; force_stall_cnt = 3;
        issue_cmd(2'd0, 1022, 4, 32'h0);
        wait_done();
        force_stall_idx = -1;
        chk("t2_stalls", stall_seen, 3);
        chk("t2_addr0", log_wr_addr[0], 1022);
        chk("t2_addr1", log_wr_addr[1], 1023);
        chk("t2_addr2", log_wr_addr[2], 0);
        chk("t2_addr3", log_wr_addr[3], 1);
        chk("t2_stall_gap", log_wr_cyc[1] - log_wr_cyc[0], 4);
`ifndef MEM_TEST_LFSR_EN
        chk("t2_data2", log_wr_data[2], 32'h2);
`endif

        // Verify with a single corruption at 7, then at 3 and 9.
        preload(0, 16, 32'h5);
        ram[7] = ram[7] ^ 32'h0000_0100;
        issue_cmd(2'd1, 0, 16, 32'h5);
        wait_done();
        chk("t3_error", error, 1'b1);
        chk("t3_count", err_count, 1);
        chk("t3_first", first_err_addr, 7);
        preload(0, 16, 32'h5);
        ram[3] = ram[3] ^ 32'h8000_0000;
        ram[9] = ram[9] ^ 32'h0000_0001;
        issue_cmd(2'd1, 0, 16, 32'h5);
        wait_done();
        chk("t4_count", err_count, 2);
        chk("t4_first", first_err_addr, 3);

        // Zero-length command.
        issue_cmd(2'd2, 100, 0, 32'h77);
        wait_done();
        chk("t5_latency", done_cyc - start_cyc, 2);
        chk("t5_no_rw", rw_seen, 0);

        // Reset in the middle of a verify.
        rd_lat_max = 4;
        preload(200, 8, 32'hABC);
        ram[200] = ram[200] ^ 32'h10;
        issue_cmd(2'd1, 200, 8, 32'hABC);
        n = 0;
        while (!(log_rd_addr.size() >= 3 && pend) && n < 1000) begin step(); n++; end
        chk("t6_reached_rd_wait", pend, 1'b1);
        chk("t6_error_before_reset", error, 1'b1);
        reset = 1'b1;
        step();
        chk_all_zero("t6");
        reset = 1'b0;
        exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd_addr.delete();
        done_count = 0;
        repeat (5) step();
        chk("t6_no_done", done_count, 0);
        issue_cmd(2'd1, 200, 8, 32'hABC);
        wait_done();
        chk("t6_rerun_first", first_err_addr, 200);

`ifdef MEM_TEST_LFSR_EN
        rd_lat_max = 1;
        issue_cmd(2'd0, 50, 2, 32'h0);
        wait_done();
        chk("lfsr_first_word", log_wr_data[0], 32'h1);
        chk("lfsr_second_word", log_wr_data[1], 32'h8020_0003);
`endif

        // Randomized commands with stalls, variable latency and stray valids.
        stall_en = 1; junk_en = 1; rd_lat_max = 3;
        for (int t = 0; t < 10; t++) begin
            md = 2'($urandom_range(3));
            b = int'($urandom_range(1023));
            len = int'($urandom_range(48, 1));
            sd = $urandom;
            if (t == 4) len = 20;
            if (t == 9) begin md = 2'd2; len = 1024; end
            if (md == 2'd1) begin
                preload(b, len, sd);
                repeat ($urandom_range(3)) begin
                    n = (b + int'($urandom_range(len - 1))) % 1024;
                    ram[n] = ram[n] ^ (32'h1 << $urandom_range(31));
                end
            end
            issue_cmd(md, b, len, sd);
            if (t == 4) poke_start();
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
